pipe_stage_reg: RTL

Parametrised pipeline stage register for the five-stage core. It carries an arbitrary payload between stages with a valid/ready handshake, a hazard stall, and a flush that injects a NOP bubble. An optional two-entry skid buffer registers the upstream ready path. It replaces the fixed-width IF/ID register and serves every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 20 ++
 rtl/pipe_stage_reg_if.sv | 17 +
 rtl/pipe_sat_cnt.sv | 37 +++
 rtl/pipe_stage_reg.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline stage register.
//   occ_state_e   : occupancy state of the stage (EMPTY/ONE/TWO)
//   OCC_W         : width of the occupancy field
//   NOP_INSN_*    : candidate bubble encodings for the core's instruction payload
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  // All-zero bubble is the default; the canonical RISC-V NOP (addi x0, x0, 0)
  // is kept for stages that decode the instruction field of the payload.
  localparam logic [31:0] NOP_INSN_ZERO = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN_ADDI = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel between two pipeline stages.
//   valid : producer has an entry
//   ready : consumer can accept
//   data  : payload, DATA_W bits
// master = producer side, slave = consumer side.
interface pipe_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with an increment of 0..2 per cycle.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset, clears the count
//   inc_i   : amount to add this cycle (0..2)
//   cnt_o   : current count, sticks at 2^W-1
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [1:0]   inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

  logic [W-1:0] cnt_q;
  logic [W+1:0] sum;

  // Two guard bits so the compare sees the overflow even for W=1.
  assign sum = {2'b00, cnt_q} + {{W{1'b0}}, inc_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (sum > MAX) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= sum[W-1:0];
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hazard stall and flush.
// Optional feature macro: PIPE_STAGE_SKID_EN (two-entry skid buffer with a
// registered ready; when undefined a single register with combinational ready).
//   clk_i         : clock, rising edge
//   rst_n_i       : asynchronous active-low reset
//   up            : upstream channel (valid_i/ready_o/data_i)
//   dn            : downstream channel (valid_o/ready_i/data_o)
//   stall_i       : hazard hold, behaves as downstream not ready
//   flush_i       : drop held and incoming entries, output a bubble
//   occupancy_o   : entries held (0..2)
//   flushed_cnt_o : saturating count of valid entries discarded by flush
//
// state | meaning (skid build)
// EMPTY | nothing held, bubble on the output
// ONE   | one entry in main register, presented downstream
// TWO   | main presented, second entry parked in skid register, upstream blocked
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pipe_stage_if.slave        up,
  pipe_stage_if.master       dn,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [OCC_W-1:0]   occupancy_o,
  output logic [CNT_W-1:0]   flushed_cnt_o
);

  logic              up_xfer;
  logic              dn_xfer;
  logic [DATA_W-1:0] main_q;
  logic [OCC_W-1:0]  held;
  logic [1:0]        flush_inc;

`ifdef PIPE_STAGE_SKID_EN

  occ_state_e        state_q, state_d;
  logic [DATA_W-1:0] skid_q;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (up_xfer) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (up_xfer && dn_xfer) begin
            load_main_in = 1'b1;
          end else if (up_xfer) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (dn_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (dn_xfer) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Payload registers hold stale data when empty; the output mux hides it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else begin
      if (load_main_in) begin
        main_q <= up.data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= up.data;
      end
    end
  end

  // Ready comes straight from the state flop: no path from ready_i/stall_i.
  assign up.ready = (state_q != TWO);
  assign dn.valid = (state_q != EMPTY);
  assign held     = state_q;

`else

  logic valid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      main_q  <= NOP_VALUE;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (up_xfer) begin
      valid_q <= 1'b1;
      main_q  <= up.data;
    end else if (dn_xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign up.ready = !valid_q | (dn.ready & !stall_i);
  assign dn.valid = valid_q;
  assign held     = {1'b0, valid_q};

`endif

  assign up_xfer     = up.valid & up.ready;
  assign dn_xfer     = dn.valid & dn.ready & !stall_i;
  assign dn.data     = dn.valid ? main_q : NOP_VALUE;
  assign occupancy_o = held;

  // Held entries plus an entry arriving on the flush edge never exceed two:
  // the skid build refuses input in TWO, the single build holds at most one.
  assign flush_inc = flush_i ? (held + {1'b0, up_xfer}) : 2'd0;

  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (flush_inc),
    .cnt_o   (flushed_cnt_o)
  );

endmodule
